// File: rtl/axi_interconnect_pkg.sv
// Shared types for the AXI interconnect write/read arbiters.
// Holds response encodings, the arbiter state and master id types.
package axi_interconnect_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      IDLE,
      AW,
      W
   } state_t;

   typedef logic master_id_t;

endpackage

// File: rtl/axi_order_fifo.sv
// Order FIFO of 1-bit master ids; the head names the owner of the
// oldest accepted transaction still awaiting its response.
module axi_order_fifo
   import axi_interconnect_pkg::*;
#(
   parameter int Depth = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  master_id_t push_id,
   input  logic       pop,
   output master_id_t head,
   output logic       full,
   output logic       empty
);

   localparam int PW = $clog2(Depth);
   localparam logic [PW:0] FullCnt = Depth[PW:0];

   master_id_t mem [Depth];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [PW:0] count;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: entries are only read once pushed.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_id;
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == FullCnt);
   assign empty = (count == '0);

endmodule

// File: rtl/axi_write_arbiter_2_1.sv
// 2-to-1 AXI write arbiter: round-robin AW grant with W burst lock,
// B responses steered back to the owner recorded in the order FIFO.
module axi_write_arbiter_2_1
   import axi_interconnect_pkg::*;
#(
   parameter int Addr_Width      = 32,
   parameter int Data_Width      = 32,
   parameter int Len_Width       = 8,
   parameter int Max_Outstanding = 4
) (
   input  logic                  ACLK,
   input  logic                  ARESETN,
   input  logic [Addr_Width-1:0] M0_AWADDR,
   input  logic [Len_Width-1:0]  M0_AWLEN,
   input  logic                  M0_AWVALID,
   output logic                  M0_AWREADY,
   input  logic [Data_Width-1:0] M0_WDATA,
   input  logic                  M0_WLAST,
   input  logic                  M0_WVALID,
   output logic                  M0_WREADY,
   output logic [1:0]            M0_BRESP,
   output logic                  M0_BVALID,
   input  logic                  M0_BREADY,
   input  logic [Addr_Width-1:0] M1_AWADDR,
   input  logic [Len_Width-1:0]  M1_AWLEN,
   input  logic                  M1_AWVALID,
   output logic                  M1_AWREADY,
   input  logic [Data_Width-1:0] M1_WDATA,
   input  logic                  M1_WLAST,
   input  logic                  M1_WVALID,
   output logic                  M1_WREADY,
   output logic [1:0]            M1_BRESP,
   output logic                  M1_BVALID,
   input  logic                  M1_BREADY,
   output logic [Addr_Width-1:0] S_AWADDR,
   output logic [Len_Width-1:0]  S_AWLEN,
   output logic                  S_AWVALID,
   input  logic                  S_AWREADY,
   output logic [Data_Width-1:0] S_WDATA,
   output logic                  S_WLAST,
   output logic                  S_WVALID,
   input  logic                  S_WREADY,
   input  logic [1:0]            S_BRESP,
   input  logic                  S_BVALID,
   output logic                  S_BREADY
);

   state_t     state;
   state_t     state_next;
   master_id_t grant;
   master_id_t grant_next;
   master_id_t last_grant;

   master_id_t fifo_head;
   logic       fifo_full;
   logic       fifo_empty;
   logic       aw_hs;
   logic       b_hs;
   logic       b_valid;
   logic       sel_wvalid;
   logic       sel_wlast;

   assign aw_hs = (state == AW) && S_AWREADY;

   // last_grant resets to M1 so the first tie after reset goes to M0.
   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         state      <= IDLE;
         grant      <= 1'b0;
         last_grant <= 1'b1;
      end else begin
         state <= state_next;
         grant <= grant_next;
         if (aw_hs) last_grant <= grant;
      end
   end

   assign sel_wvalid = grant ? M1_WVALID : M0_WVALID;
   assign sel_wlast  = grant ? M1_WLAST  : M0_WLAST;

   always_comb begin
      state_next = state;
      grant_next = grant;
      unique case (state)
         IDLE: begin
            if (!fifo_full && (M0_AWVALID || M1_AWVALID)) begin
               state_next = AW;
               if (M0_AWVALID && M1_AWVALID) grant_next = ~last_grant;
               else                          grant_next = M1_AWVALID;
            end
         end
         AW: begin
            if (S_AWREADY) state_next = W;
         end
         W: begin
            if (sel_wvalid && S_WREADY && sel_wlast) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      S_AWVALID  = 1'b0;
      S_AWADDR   = '0;
      S_AWLEN    = '0;
      M0_AWREADY = 1'b0;
      M1_AWREADY = 1'b0;
      S_WVALID   = 1'b0;
      S_WDATA    = '0;
      S_WLAST    = 1'b0;
      M0_WREADY  = 1'b0;
      M1_WREADY  = 1'b0;
      unique case (state)
         AW: begin
            S_AWVALID  = 1'b1;
            S_AWADDR   = grant ? M1_AWADDR : M0_AWADDR;
            S_AWLEN    = grant ? M1_AWLEN  : M0_AWLEN;
            M0_AWREADY = ~grant & S_AWREADY;
            M1_AWREADY = grant & S_AWREADY;
         end
         W: begin
            S_WVALID  = sel_wvalid;
            S_WDATA   = grant ? M1_WDATA : M0_WDATA;
            S_WLAST   = sel_wlast;
            M0_WREADY = ~grant & S_WREADY;
            M1_WREADY = grant & S_WREADY;
         end
         default: begin
         end
      endcase
   end

   // Response routing runs independently of the grant state machine.
   assign b_valid   = S_BVALID & ~fifo_empty;
   assign M0_BVALID = b_valid & ~fifo_head;
   assign M1_BVALID = b_valid & fifo_head;
   assign M0_BRESP  = fifo_head ? 2'b00 : S_BRESP;
   assign M1_BRESP  = fifo_head ? S_BRESP : 2'b00;
   assign S_BREADY  = ~fifo_empty & (fifo_head ? M1_BREADY : M0_BREADY);
   assign b_hs      = S_BVALID & S_BREADY;

   axi_order_fifo #(
      .Depth(Max_Outstanding)
   ) u_fifo (
      .clk    (ACLK),
      .rst_n  (ARESETN),
      .push   (aw_hs),
      .push_id(grant),
      .pop    (b_hs),
      .head   (fifo_head),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

endmodule

// File: tb/tb_axi_write_arbiter_2_1.sv
// Directed bench for axi_write_arbiter_2_1: a cycle table for the
// single-master and backpressure paths, then hand-written corner sequences.
module tb_axi_write_arbiter_2_1;
   import axi_interconnect_pkg::*;

   logic        ACLK = 1'b0;
   logic        ARESETN;
   logic [31:0] M0_AWADDR, M1_AWADDR, S_AWADDR;
   logic [7:0]  M0_AWLEN, M1_AWLEN, S_AWLEN;
   logic        M0_AWVALID, M0_AWREADY, M1_AWVALID, M1_AWREADY;
   logic [31:0] M0_WDATA, M1_WDATA, S_WDATA;
   logic        M0_WLAST, M1_WLAST, S_WLAST;
   logic        M0_WVALID, M0_WREADY, M1_WVALID, M1_WREADY;
   logic [1:0]  M0_BRESP, M1_BRESP, S_BRESP;
   logic        M0_BVALID, M0_BREADY, M1_BVALID, M1_BREADY;
   logic        S_AWVALID, S_AWREADY, S_WVALID, S_WREADY;
   logic        S_BVALID, S_BREADY;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 ACLK = ~ACLK;

   axi_write_arbiter_2_1 dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .M0_AWADDR(M0_AWADDR), .M0_AWLEN(M0_AWLEN),
      .M0_AWVALID(M0_AWVALID), .M0_AWREADY(M0_AWREADY),
      .M0_WDATA(M0_WDATA), .M0_WLAST(M0_WLAST),
      .M0_WVALID(M0_WVALID), .M0_WREADY(M0_WREADY),
      .M0_BRESP(M0_BRESP), .M0_BVALID(M0_BVALID), .M0_BREADY(M0_BREADY),
      .M1_AWADDR(M1_AWADDR), .M1_AWLEN(M1_AWLEN),
      .M1_AWVALID(M1_AWVALID), .M1_AWREADY(M1_AWREADY),
      .M1_WDATA(M1_WDATA), .M1_WLAST(M1_WLAST),
      .M1_WVALID(M1_WVALID), .M1_WREADY(M1_WREADY),
      .M1_BRESP(M1_BRESP), .M1_BVALID(M1_BVALID), .M1_BREADY(M1_BREADY),
      .S_AWADDR(S_AWADDR), .S_AWLEN(S_AWLEN),
      .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
      .S_WDATA(S_WDATA), .S_WLAST(S_WLAST),
      .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
      .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY)
   );

   typedef struct packed {
      logic        aw0v;
      logic        w0v;
      logic [31:0] wd;
      logic        wl;
      logic        w1v;
      logic        s_awr;
      logic        s_wr;
      logic        s_bv;
      logic [1:0]  bresp;
      logic        b0r;
      logic        e_awv;
      logic [31:0] e_awaddr;
      logic        e_aw0r;
      logic        e_aw1r;
      logic        e_wv;
      logic [31:0] e_wdata;
      logic        e_wl;
      logic        e_w0r;
      logic        e_w1r;
      logic        e_b0v;
      logic [1:0]  e_b0resp;
      logic        e_b1v;
      logic        e_br;
   } vec_t;

   localparam int NV = 19;
   vec_t tv [NV];

   task automatic chk(input string name, input logic [127:0] act,
                      input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic idle_inputs();
      M0_AWVALID = 0; M1_AWVALID = 0;
      M0_WVALID = 0;  M1_WVALID = 0;
      M0_WLAST = 0;   M1_WLAST = 0;
      M0_WDATA = 0;   M1_WDATA = 0;
      M0_BREADY = 0;  M1_BREADY = 0;
      S_AWREADY = 0;  S_WREADY = 0;
      S_BVALID = 0;   S_BRESP = 0;
   endtask

   task automatic reset_dut();
      ARESETN = 0;
      idle_inputs();
      tick();
      chk("reset_empty", dut.u_fifo.empty, 1);
      ARESETN = 1;
      tick();
   endtask

   task automatic do_aw(input bit id, input logic [31:0] addr,
                        input logic [7:0] len);
      bit hit;
      hit = 0;
      S_AWREADY = 1;
      if (id) begin
         M1_AWVALID = 1; M1_AWADDR = addr; M1_AWLEN = len;
      end else begin
         M0_AWVALID = 1; M0_AWADDR = addr; M0_AWLEN = len;
      end
      for (int k = 0; k < 8 && !hit; k++) begin
         #1;
         if (S_AWVALID && (id ? M1_AWREADY : M0_AWREADY)) begin
            hit = 1;
            chk("aw_addr", S_AWADDR, addr);
            chk("aw_len", S_AWLEN, len);
         end
         tick();
      end
      chk("aw_handshake", hit, 1);
      M0_AWVALID = 0; M1_AWVALID = 0;
   endtask

   task automatic do_w(input bit id, input int n, input logic [31:0] base);
      bit hit;
      S_WREADY = 1;
      for (int b = 0; b < n; b++) begin
         hit = 0;
         if (id) begin
            M1_WVALID = 1; M1_WDATA = base + b; M1_WLAST = (b == n - 1);
         end else begin
            M0_WVALID = 1; M0_WDATA = base + b; M0_WLAST = (b == n - 1);
         end
         for (int k = 0; k < 8 && !hit; k++) begin
            #1;
            if (S_WVALID && (id ? M1_WREADY : M0_WREADY)) begin
               hit = 1;
               chk("w_data", S_WDATA, base + b);
               chk("w_last", S_WLAST, (b == n - 1));
            end
            tick();
         end
         chk("w_handshake", hit, 1);
      end
      M0_WVALID = 0; M1_WVALID = 0;
      M0_WLAST = 0;  M1_WLAST = 0;
      S_WREADY = 0;
   endtask

   task automatic do_b(input bit owner, input logic [1:0] resp);
      S_BVALID = 1; S_BRESP = resp;
      M0_BREADY = 1; M1_BREADY = 1;
      #1;
      chk("b_valids", {M0_BVALID, M1_BVALID}, owner ? 2'b01 : 2'b10);
      chk("b_resp", owner ? M1_BRESP : M0_BRESP, resp);
      chk("b_other_resp", owner ? M0_BRESP : M1_BRESP, 0);
      chk("b_sready", S_BREADY, 1);
      tick();
      S_BVALID = 0; M0_BREADY = 0; M1_BREADY = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      // single master burst, then empty-FIFO response, then W backpressure
      tv[0]  = '{'1,'0,'0,'0,'0,'1,'0,'0,'0,'0,
                 '0,'0,'0,'0,'0,'0,'0,'0,'0,'0,'0,'0,'0};
      tv[1]  = '{'1,'0,'0,'0,'0,'1,'0,'0,'0,'0,
                 '1,32'h1000,'1,'0,'0,'0,'0,'0,'0,'0,'0,'0,'0};
      tv[2]  = '{'0,'1,32'hA0,'0,'0,'1,'1,'0,'0,'0,
                 '0,'0,'0,'0,'1,32'hA0,'0,'1,'0,'0,'0,'0,'0};
      tv[3]  = '{'0,'1,32'hA1,'0,'0,'1,'1,'0,'0,'0,
                 '0,'0,'0,'0,'1,32'hA1,'0,'1,'0,'0,'0,'0,'0};
      tv[4]  = '{'0,'1,32'hA2,'0,'0,'1,'1,'0,'0,'0,
                 '0,'0,'0,'0,'1,32'hA2,'0,'1,'0,'0,'0,'0,'0};
      tv[5]  = '{'0,'1,32'hA3,'1,'0,'1,'1,'0,'0,'0,
                 '0,'0,'0,'0,'1,32'hA3,'1,'1,'0,'0,'0,'0,'0};
      tv[6]  = '{'0,'0,'0,'0,'0,'0,'0,'1,2'b00,'1,
                 '0,'0,'0,'0,'0,'0,'0,'0,'0,'1,2'b00,'0,'1};
      tv[7]  = '{'0,'0,'0,'0,'0,'0,'0,'1,2'b00,'1,
                 '0,'0,'0,'0,'0,'0,'0,'0,'0,'0,'0,'0,'0};
      tv[8]  = '{'1,'0,'0,'0,'0,'1,'0,'0,'0,'0,
                 '0,'0,'0,'0,'0,'0,'0,'0,'0,'0,'0,'0,'0};
      tv[9]  = '{'1,'0,'0,'0,'0,'1,'0,'0,'0,'0,
                 '1,32'h1000,'1,'0,'0,'0,'0,'0,'0,'0,'0,'0,'0};
      tv[10] = '{'0,'1,32'hB0,'0,'1,'1,'1,'0,'0,'0,
                 '0,'0,'0,'0,'1,32'hB0,'0,'1,'0,'0,'0,'0,'0};
      tv[11] = '{'0,'1,32'hB1,'0,'1,'1,'0,'0,'0,'0,
                 '0,'0,'0,'0,'1,32'hB1,'0,'0,'0,'0,'0,'0,'0};
      tv[12] = '{'0,'1,32'hB1,'0,'1,'1,'1,'0,'0,'0,
                 '0,'0,'0,'0,'1,32'hB1,'0,'1,'0,'0,'0,'0,'0};
      tv[13] = '{'0,'1,32'hB2,'0,'1,'1,'0,'0,'0,'0,
                 '0,'0,'0,'0,'1,32'hB2,'0,'0,'0,'0,'0,'0,'0};
      tv[14] = '{'0,'1,32'hB2,'0,'1,'1,'1,'0,'0,'0,
                 '0,'0,'0,'0,'1,32'hB2,'0,'1,'0,'0,'0,'0,'0};
      tv[15] = '{'0,'1,32'hB3,'1,'1,'1,'0,'0,'0,'0,
                 '0,'0,'0,'0,'1,32'hB3,'1,'0,'0,'0,'0,'0,'0};
      tv[16] = '{'0,'1,32'hB3,'1,'1,'1,'1,'0,'0,'0,
                 '0,'0,'0,'0,'1,32'hB3,'1,'1,'0,'0,'0,'0,'0};
      tv[17] = '{'0,'0,'0,'0,'0,'0,'0,'1,2'b10,'0,
                 '0,'0,'0,'0,'0,'0,'0,'0,'0,'1,2'b10,'0,'0};
      tv[18] = '{'0,'0,'0,'0,'0,'0,'0,'1,2'b10,'1,
                 '0,'0,'0,'0,'0,'0,'0,'0,'0,'1,2'b10,'0,'1};

      ARESETN = 0;
      idle_inputs();
      M0_AWADDR = 0; M1_AWADDR = 0; M0_AWLEN = 0; M1_AWLEN = 0;
      S_BVALID = 1; M0_BREADY = 1; M1_BREADY = 1;
      tick();
      tick();
      chk("reset_outputs",
          {S_AWVALID, S_WVALID, S_BREADY, M0_AWREADY, M1_AWREADY,
           M0_WREADY, M1_WREADY, M0_BVALID, M1_BVALID},
          0);
      chk("reset_data", {S_AWADDR, S_AWLEN, S_WDATA, S_WLAST}, 0);
      chk("reset_count", dut.u_fifo.count, 0);
      ARESETN = 1;
      idle_inputs();
      tick();

      M0_AWADDR = 32'h1000; M0_AWLEN = 8'd3;
      M1_WDATA = 32'hDEAD; M1_BREADY = 1;
      for (int i = 0; i < NV; i++) begin
         M0_AWVALID = tv[i].aw0v;
         M0_WVALID  = tv[i].w0v;
         M0_WDATA   = tv[i].wd;
         M0_WLAST   = tv[i].wl;
         M1_WVALID  = tv[i].w1v;
         S_AWREADY  = tv[i].s_awr;
         S_WREADY   = tv[i].s_wr;
         S_BVALID   = tv[i].s_bv;
         S_BRESP    = tv[i].bresp;
         M0_BREADY  = tv[i].b0r;
         #1;
         chk($sformatf("vec%0d", i),
             {S_AWVALID, S_AWADDR, M0_AWREADY, M1_AWREADY, S_WVALID,
              S_WDATA, S_WLAST, M0_WREADY, M1_WREADY, M0_BVALID,
              M0_BRESP, M1_BVALID, S_BREADY},
             {tv[i].e_awv, tv[i].e_awaddr, tv[i].e_aw0r, tv[i].e_aw1r,
              tv[i].e_wv, tv[i].e_wdata, tv[i].e_wl, tv[i].e_w0r,
              tv[i].e_w1r, tv[i].e_b0v, tv[i].e_b0resp, tv[i].e_b1v,
              tv[i].e_br});
         tick();
      end
      idle_inputs();

      // tie after reset: M0 first; then a second tie goes to M1
      reset_dut();
      M0_AWADDR = 32'h100; M1_AWADDR = 32'h200;
      M0_AWLEN = 0; M1_AWLEN = 0;
      M0_AWVALID = 1; M1_AWVALID = 1; S_AWREADY = 1;
      #1;
      chk("tie_idle_awvalid", S_AWVALID, 0);
      tick();
      chk("tie_first_addr", S_AWADDR, 32'h100);
      chk("tie_first_ready", {M0_AWREADY, M1_AWREADY}, 2'b10);
      tick();
      M0_AWVALID = 0;
      M0_WVALID = 1; M0_WDATA = 32'h11; M0_WLAST = 1; S_WREADY = 1;
      #1;
      chk("tie_w0", {S_WVALID, S_WDATA, M0_WREADY, M1_WREADY},
          {1'b1, 32'h11, 2'b10});
      tick();
      M0_WVALID = 0; M0_WLAST = 0;
      M0_AWVALID = 1; M0_AWADDR = 32'h180;
      tick();
      M0_AWVALID = 0;
      #1;
      chk("rr_second_addr", S_AWADDR, 32'h200);
      chk("rr_second_ready", {M0_AWREADY, M1_AWREADY}, 2'b01);
      tick();
      M1_AWVALID = 0;
      M1_WVALID = 1; M1_WDATA = 32'h22; M1_WLAST = 1;
      #1;
      chk("tie_w1", {S_WVALID, S_WDATA, M0_WREADY, M1_WREADY},
          {1'b1, 32'h22, 2'b01});
      tick();
      idle_inputs();
      do_b(0, RESP_OKAY);
      do_b(1, RESP_SLVERR);

      // order FIFO full: fifth AW stalls until a response pops
      reset_dut();
      for (int i = 0; i < 4; i++) begin
         do_aw(0, 32'h2000 + 32'(i * 16), 8'd0);
         do_w(0, 1, 32'h300 + 32'(i));
      end
      chk("full_count", dut.u_fifo.count, 4);
      M1_AWVALID = 1; M1_AWADDR = 32'h5000; M1_AWLEN = 0; S_AWREADY = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("full_stall", {S_AWVALID, M1_AWREADY}, 2'b00);
         tick();
      end
      do_b(0, RESP_OKAY);
      #1;
      chk("full_after_pop_idle", S_AWVALID, 0);
      tick();
      chk("full_grant_addr", {S_AWVALID, S_AWADDR}, {1'b1, 32'h5000});
      do_aw(1, 32'h5000, 8'd0);
      do_w(1, 1, 32'h55);
      do_b(0, RESP_OKAY);
      do_b(0, RESP_OKAY);
      do_b(0, RESP_SLVERR);
      do_b(1, RESP_OKAY);
      chk("full_drained", dut.u_fifo.count, 0);

      // push and pop in the same cycle at count 2
      reset_dut();
      do_aw(0, 32'h3000, 8'd0);
      do_w(0, 1, 32'h30);
      do_aw(1, 32'h3100, 8'd0);
      do_w(1, 1, 32'h31);
      chk("pp_count_before", dut.u_fifo.count, 2);
      M0_AWVALID = 1; M0_AWADDR = 32'h3200; M0_AWLEN = 0; S_AWREADY = 1;
      tick();
      S_BVALID = 1; S_BRESP = RESP_OKAY; M0_BREADY = 1;
      #1;
      chk("pp_both_hs", {M0_AWREADY, S_BREADY, M0_BVALID}, 3'b111);
      tick();
      M0_AWVALID = 0; S_BVALID = 0; M0_BREADY = 0;
      chk("pp_count_after", dut.u_fifo.count, 2);
      do_w(0, 1, 32'h32);
      do_b(1, RESP_SLVERR);
      do_b(0, RESP_OKAY);
      chk("pp_drained", dut.u_fifo.count, 0);

      // reset in the middle of a burst
      reset_dut();
      do_aw(0, 32'h4000, 8'd3);
      S_WREADY = 1;
      M0_WVALID = 1; M0_WDATA = 32'h40;
      tick();
      M0_WDATA = 32'h41;
      tick();
      M0_WDATA = 32'h42;
      ARESETN = 0;
      S_BVALID = 1; M0_BREADY = 1; M1_BREADY = 1;
      tick();
      chk("mid_reset_outputs",
          {S_AWVALID, S_WVALID, S_BREADY, M0_AWREADY, M1_AWREADY,
           M0_WREADY, M1_WREADY, M0_BVALID, M1_BVALID},
          0);
      chk("mid_reset_empty", dut.u_fifo.empty, 1);
      ARESETN = 1;
      idle_inputs();
      tick();
      do_aw(1, 32'h4400, 8'd1);
      do_w(1, 2, 32'h44);
      do_b(1, RESP_OKAY);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
